// File: rtl/vram_lane_mux_if.sv
// vram_lane_mux_if: CPU byte port, video word port and clear handshake of the lane-muxed VRAM
interface vram_lane_mux_if #(
    parameter int AW    = 10,
    parameter int LANES = 2
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 0;
    logic [AW+LW-1:0]   cad;
    logic               cwr;
    logic [7:0]         cwd;
    logic [7:0]         crd;
    logic               cwait;
    logic [AW-1:0]      vad;
    logic [8*LANES-1:0] vrd;
    logic               clr;
    logic               clrbusy;
    modport master (output cad, cwr, cwd, vad, clr, input crd, cwait, vrd, clrbusy);
    modport slave  (input cad, cwr, cwd, vad, clr, output crd, cwait, vrd, clrbusy);
endinterface

// File: rtl/vram_lane_mux.sv
// vram_lane_mux: byte-lane VRAM with CPU byte port, full-width video port and hardware clear engine
module vram_lane_mux #(
    parameter int         AW     = 10,
    parameter int         LANES  = 2,
    parameter logic [7:0] CLRVAL = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    vram_lane_mux_if.slave  bus
);
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 0;
    localparam int LWS   = LW > 0 ? LW : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t               r_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_clr_q;
    logic [7:0]           r_crd;
    logic [8*LANES-1:0]   r_vrd;
    logic [7:0]           r_mem [LANES][DEPTH];

    logic [LWS-1:0]       w_lane;
    logic [AW-1:0]        w_word;
    logic                 w_busy;
    logic                 w_cpu_we;

    // With a single lane the shift leaves nothing, so the lane index is always 0
    assign w_lane   = LWS'(bus.cad >> AW);
    assign w_word   = bus.cad[AW-1:0];
    assign w_busy   = r_state == FILL;
    assign w_cpu_we = bus.cwr && !w_busy;

    // Clear engine: start on a CLR rising edge seen in IDLE, sweep every word once, then idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clr_q <= 1'b0;
        end else begin
            r_clr_q <= bus.clr;
            if (r_state == IDLE) begin
                if (bus.clr && !r_clr_q) begin
                    r_state <= FILL;
                    r_cnt   <= '0;
                end
            end else begin
                r_cnt <= r_cnt + AW'(1);
                if (&r_cnt)
                    r_state <= IDLE;
            end
        end
    end

    // RAM write port: the fill owns all lanes while busy, otherwise the CPU writes its one lane
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_busy)
                r_mem[k][r_cnt] <= CLRVAL;
            else if (w_cpu_we && w_lane == LWS'(k))
                r_mem[k][w_word] <= bus.cwd;
        end
    end

    // Registered reads (old data on a same-cycle write); CPU read data freezes during the fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crd <= '0;
            r_vrd <= '0;
        end else begin
            if (!w_busy)
                r_crd <= r_mem[w_lane][w_word];
            for (int k = 0; k < LANES; k++)
                r_vrd[8*k +: 8] <= r_mem[k][bus.vad];
        end
    end

    assign bus.crd     = r_crd;
    assign bus.vrd     = r_vrd;
    assign bus.clrbusy = w_busy;
    assign bus.cwait   = w_busy;
endmodule

// File: tb/tb_vram_lane_mux.sv
// tb_vram_lane_mux: random and directed checks of vram_lane_mux against a memory-array reference model
module tb_vram_lane_mux;
    localparam logic [7:0] CLR_V = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_err = 0;
    int   n_checks = 0;

    vram_lane_mux_if #(.AW(10), .LANES(2)) bus ();
    vram_lane_mux_if #(.AW(8), .LANES(4))  bus4 ();

    vram_lane_mux #(.AW(10), .LANES(2), .CLRVAL(CLR_V)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    vram_lane_mux #(.AW(8), .LANES(4), .CLRVAL(CLR_V)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    // reference model: plain byte array plus "fill in progress" bookkeeping
    logic [7:0]  m_mem [2][1024];
    bit          m_busy = 0;
    int          m_idx = 0;
    bit          m_clr_prev = 0;
    logic [7:0]  m_crd = '0;
    logic [15:0] m_vrd = '0;
    bit          m_live = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: predict from current inputs, advance, then compare
    task automatic cycle();
        int ln = int'(bus.cad[10]);
        int wd = int'(bus.cad[9:0]);
        m_vrd = {m_mem[1][bus.vad], m_mem[0][bus.vad]};
        if (!m_busy)
            m_crd = m_mem[ln][wd];
        if (m_busy) begin
            m_mem[0][m_idx] = CLR_V;
            m_mem[1][m_idx] = CLR_V;
            m_idx++;
            if (m_idx == 1024)
                m_busy = 0;
        end else begin
            if (bus.cwr)
                m_mem[ln][wd] = bus.cwd;
            if (bus.clr && !m_clr_prev) begin
                m_busy = 1;
                m_idx = 0;
            end
        end
        m_clr_prev = bus.clr;
        @(posedge clk);
        #1;
        chk("busy", bus.clrbusy, m_busy);
        chk("cwait", bus.cwait, m_busy);
        if (m_live) begin
            chk("vrd", bus.vrd, m_vrd);
            chk("crd", bus.crd, m_crd);
        end
    endtask

    // trigger a clear and count the cycles CLRBUSY stays high
    task automatic run_fill(output int n, input int poke);
        n = 0;
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        for (int i = 0; i < 1100 && bus.clrbusy; i++) begin
            bus.clr = (i == poke);
            cycle();
            n++;
        end
        bus.clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bus.cad = '0; bus.cwr = 0; bus.cwd = '0; bus.vad = '0; bus.clr = 0;
        bus4.cad = '0; bus4.cwr = 0; bus4.cwd = '0; bus4.vad = '0; bus4.clr = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_crd", bus.crd, 8'h00);
        chk("rst_vrd", bus.vrd, 16'h0000);
        chk("rst_busy", bus.clrbusy, 1'b0);
        chk("rst_cwait", bus.cwait, 1'b0);
        chk("rst_vrd4", bus4.vrd, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // initial clear brings the RAM to a known state
        run_fill(n, -1);
        chk("init_len", n, 1024);
        cycle();
        m_live = 1;

        // test 1: write lane 1 of word 5, read back both ports
        bus.cad = 11'h405; bus.cwr = 1; bus.cwd = 8'hA5;
        cycle();
        bus.cwr = 0; bus.vad = 10'h005;
        cycle();
        chk("t1_vrd_hi", bus.vrd[15:8], 8'hA5);
        chk("t1_lane0", bus.vrd[7:0], 8'h00);
        chk("t1_crd", bus.crd, 8'hA5);

        // test 2: read-before-write on the video port
        bus.cad = 11'h005; bus.cwr = 1; bus.cwd = 8'h3C;
        cycle();
        chk("t2_old", bus.vrd[7:0], 8'h00);
        bus.cwr = 0;
        cycle();
        chk("t2_new", bus.vrd[7:0], 8'h3C);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bus.cad = 11'($urandom);
            bus.cwr = 1'($urandom);
            bus.cwd = 8'($urandom);
            bus.vad = ($urandom_range(0, 3) == 0) ? bus.cad[9:0] : 10'($urandom);
            cycle();
        end
        bus.cwr = 0;

        // test 3: clear over preloaded RAM, second edge mid-fill ignored
        run_fill(n, 500);
        chk("t3_len", n, 1024);
        for (int i = 0; i < 16; i++) begin
            bus.vad = 10'($urandom);
            cycle();
            chk("t3_zero", bus.vrd, 16'h0000);
        end

        // test 4: CPU write held through the fill lands after CLRBUSY falls
        bus.cad = 11'h7FF; bus.cwr = 1; bus.cwd = 8'h5A;
        run_fill(n, -1);
        chk("t4_len", n, 1024);
        cycle();
        bus.cwr = 0; bus.vad = 10'h3FF;
        cycle();
        cycle();
        chk("t4_word", bus.vrd[15:8], 8'h5A);

        // test 5: reset in the middle of a fill
        for (int i = 300; i < 310; i++) begin
            bus.cad = 11'(i); bus.cwr = 1; bus.cwd = 8'(i + 1);
            cycle();
        end
        bus.cwr = 0;
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        repeat (300) cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", bus.clrbusy, 1'b0);
        chk("t5_cwait", bus.cwait, 1'b0);
        m_busy = 0; m_clr_prev = 0; m_crd = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.vad = 10'd305;
        cycle();
        cycle();
        chk("t5_keep", bus.vrd[7:0], 8'd50);
        bus.vad = 10'd299;
        cycle();
        chk("t5_cleared", bus.vrd[7:0], 8'h00);
        run_fill(n, -1);
        chk("t5_len", n, 1024);

        // test 6: four-lane instance
        for (int k = 0; k < 4; k++) begin
            bus4.cad = {2'(k), 8'h10}; bus4.cwr = 1; bus4.cwd = 8'(8'h11 * (k + 1));
            cycle();
        end
        bus4.cwr = 0; bus4.vad = 8'h10; bus4.cad = {2'd2, 8'h10};
        cycle();
        chk("t6_vrd", bus4.vrd, 32'h44332211);
        chk("t6_crd", bus4.crd, 8'h33);
        chk("t6_busy", bus4.clrbusy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
